// File: rtl/stream_sink_fifo.sv
// Terminal sink for a valid-tagged stream: buffers samples in a circular store and serves host reads with 1-cycle latency.
// No backpressure upstream, so samples arriving when full are dropped, counted and flagged sticky.
module stream_sink_fifo #(
   parameter int N         = 16,
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       EN,
   input  logic                       R_IN,
   input  logic [N-1:0]               D_IN,
   input  logic                       CLR,
   input  logic                       RD_EN,
   output logic                       R_OUT,
   output logic [N-1:0]               D_OUT,
   output logic [$clog2(DEPTH):0]     COUNT,
   output logic                       EMPTY,
   output logic                       FULL,
   output logic                       DONE,
   output logic                       OVF,
   output logic [15:0]                DROP_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH     = DEPTH[AW:0];
   localparam logic [15:0] C_FRAME_LEN = FRAME_LEN[15:0];

   logic [N-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_empty;
   logic          r_full;
   logic          r_rout;
   logic [N-1:0]  r_dout;
   logic [15:0]   r_acc;
   logic          r_done;
   logic          r_ovf;
   logic [15:0]   r_drop;

   logic          w_clr;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [AW:0]   w_count_nxt;

   assign w_clr  = RST | CLR;
   assign w_pop  = RD_EN & ~r_empty;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign w_push = EN & R_IN & (~r_full | w_pop);
   assign w_drop = EN & R_IN & r_full & ~w_pop;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (w_push && !w_clr) begin
         r_mem[r_wr_ptr] <= D_IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_rout   <= 1'b0;
         r_dout   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_rout <= w_pop;
         if (w_pop) begin
            r_dout   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == C_DEPTH);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_clr) begin
         r_acc  <= '0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end else begin
         if (w_push) begin
            if (r_acc != 16'hFFFF) begin
               r_acc <= r_acc + 16'd1;
            end
            if (r_acc + 16'd1 == C_FRAME_LEN) begin
               r_done <= 1'b1;
            end
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 16'hFFFF) begin
               r_drop <= r_drop + 16'd1;
            end
         end
      end
   end

   assign R_OUT    = r_rout;
   assign D_OUT    = r_dout;
   assign COUNT    = r_count;
   assign EMPTY    = r_empty;
   assign FULL     = r_full;
   assign DONE     = r_done;
   assign OVF      = r_ovf;
   assign DROP_CNT = r_drop;

endmodule

// File: tb/tb_stream_sink_fifo.sv
// Directed bench for stream_sink_fifo (N=16, DEPTH=16, FRAME_LEN=8) with hand-computed expectations.
module tb_stream_sink_fifo;

   logic        CLK = 1'b0;
   logic        RST, EN, R_IN, CLR, RD_EN;
   logic [15:0] D_IN;
   logic        R_OUT, EMPTY, FULL, DONE, OVF;
   logic [15:0] D_OUT, DROP_CNT;
   logic [4:0]  COUNT;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   stream_sink_fifo #(.N(16), .DEPTH(16), .FRAME_LEN(8)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D_IN), .CLR(CLR),
      .RD_EN(RD_EN), .R_OUT(R_OUT), .D_OUT(D_OUT), .COUNT(COUNT),
      .EMPTY(EMPTY), .FULL(FULL), .DONE(DONE), .OVF(OVF), .DROP_CNT(DROP_CNT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      EN = 1'b1; R_IN = 1'b0; RD_EN = 1'b0; CLR = 1'b0; RST = 1'b0;
   endtask

   task automatic push(input logic [15:0] v);
      R_IN = 1'b1; D_IN = v; RD_EN = 1'b0;
      step();
      R_IN = 1'b0;
   endtask

   task automatic clear();
      idle(); CLR = 1'b1;
      step();
      CLR = 1'b0;
   endtask

   task automatic read_expect(input string tag, input logic [15:0] v);
      R_IN = 1'b0; RD_EN = 1'b1;
      step();
      RD_EN = 1'b0;
      chk({tag, "_rout"}, R_OUT, 1);
      chk({tag, "_dout"}, D_OUT, v);
   endtask

   initial begin
      idle(); D_IN = '0; RST = 1'b1;
      // T1 reset
      step(); step();
      RST = 1'b0;
      chk("t1_empty", EMPTY, 1);
      chk("t1_full", FULL, 0);
      chk("t1_count", COUNT, 0);
      chk("t1_rout", R_OUT, 0);
      chk("t1_dout", D_OUT, 0);
      chk("t1_done", DONE, 0);
      chk("t1_ovf", OVF, 0);
      chk("t1_drop", DROP_CNT, 0);

      // T2 ordering
      push(16'd1); push(16'd2); push(16'd3);
      chk("t2_count3", COUNT, 3);
      chk("t2_empty", EMPTY, 0);
      read_expect("t2_rd1", 16'd1);
      read_expect("t2_rd2", 16'd2);
      read_expect("t2_rd3", 16'd3);
      chk("t2_count0", COUNT, 0);
      chk("t2_empty1", EMPTY, 1);
      step();
      chk("t2_rout_idle", R_OUT, 0);
      chk("t2_dout_hold", D_OUT, 3);

      // T3 overflow
      clear();
      for (int i = 0; i < 16; i++) push(16'(i));
      chk("t3_full16", FULL, 1);
      chk("t3_count16", COUNT, 16);
      chk("t3_ovf_before", OVF, 0);
      push(16'd16); push(16'd17);
      chk("t3_ovf", OVF, 1);
      chk("t3_drop", DROP_CNT, 2);
      chk("t3_count_kept", COUNT, 16);
      chk("t3_done", DONE, 1);
      for (int i = 0; i < 16; i++) read_expect($sformatf("t3_rd%0d", i), 16'(i));
      chk("t3_empty", EMPTY, 1);

      // T4 full with simultaneous push/pop
      clear();
      for (int i = 0; i < 16; i++) push(16'(100 + i));
      chk("t4_full", FULL, 1);
      R_IN = 1'b1; D_IN = 16'd99; RD_EN = 1'b1;
      step();
      R_IN = 1'b0; RD_EN = 1'b0;
      chk("t4_sim_rout", R_OUT, 1);
      chk("t4_sim_dout", D_OUT, 100);
      chk("t4_count", COUNT, 16);
      chk("t4_ovf", OVF, 0);
      chk("t4_drop", DROP_CNT, 0);
      for (int i = 1; i < 16; i++) read_expect($sformatf("t4_rd%0d", i), 16'(100 + i));
      read_expect("t4_last", 16'd99);
      chk("t4_empty", EMPTY, 1);

      // T5 empty read and EN gating
      clear();
      RD_EN = 1'b1;
      step();
      RD_EN = 1'b0;
      chk("t5_rout", R_OUT, 0);
      chk("t5_dout", D_OUT, 0);
      EN = 1'b0; R_IN = 1'b1; D_IN = 16'd55;
      for (int i = 0; i < 5; i++) step();
      R_IN = 1'b0; EN = 1'b1;
      chk("t5_count", COUNT, 0);
      chk("t5_empty", EMPTY, 1);
      RD_EN = 1'b1;
      step();
      RD_EN = 1'b0;
      chk("t5_rout2", R_OUT, 0);

      // T6 frame completion and soft clear
      clear();
      for (int i = 0; i < 7; i++) push(16'(200 + i));
      chk("t6_done7", DONE, 0);
      push(16'd207);
      chk("t6_done8", DONE, 1);
      push(16'd208); push(16'd209);
      chk("t6_done_sticky", DONE, 1);
      read_expect("t6_rd", 16'd200);
      CLR = 1'b1; R_IN = 1'b1; RD_EN = 1'b1; D_IN = 16'd300;
      step();
      idle();
      chk("t6_clr_count", COUNT, 0);
      chk("t6_clr_empty", EMPTY, 1);
      chk("t6_clr_done", DONE, 0);
      chk("t6_clr_rout", R_OUT, 0);
      chk("t6_clr_dout", D_OUT, 0);
      chk("t6_clr_ovf", OVF, 0);
      step();
      chk("t6_post_count", COUNT, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
